if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/DE pipeline register.
- Owns the program counter and issues single-outstanding requests to instruction memory using a req/gnt/rvalid handshake.
- Presents {inst, pc, pc+4} with a valid flag to the IF/DE register; honours stall and branch/jump redirect from later stages.

Parameters:
- DATA_WIDTH, 32, width of PC, address, instruction and data buses.
- RESET_PC, 32'h0000_0000, PC loaded on reset (DATA_WIDTH bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  IF/DE register not enabled this cycle; the presented instruction is not consumed.
- redirect_i  in  1  flush and load a new PC (taken branch/jump).
- redirect_pc_i  in  DATA_WIDTH  redirect target.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  DATA_WIDTH  request address (equals pc_q).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  DATA_WIDTH  fetched instruction.
- inst_o  out  DATA_WIDTH  instruction to the IF/DE register.
- pc_o  out  DATA_WIDTH  PC of inst_o.
- pcn_o  out  DATA_WIDTH  pc_o + 4.
- inst_valid_o  out  1  inst_o/pc_o/pcn_o are valid.

Behaviour:
- Reset: pc_q = RESET_PC, state = IDLE, drop_q = 0. All outputs are 0 (imem_req_o, inst_valid_o, inst_o, pc_o, pcn_o, imem_addr_o = 0 while in IDLE).
- IDLE:
  - Lasts one cycle after reset release, then goes to REQ.
  - If redirect_i is high in IDLE, pc_q takes redirect_pc_i.
- REQ:
  - imem_req_o = 1, imem_addr_o = pc_q.
  - imem_gnt_i = 1 -> WAIT.
  - An ungranted request carries no commitment, so the address may change before gnt.
- WAIT:
  - imem_req_o = 0.
  - imem_rvalid_i = 1 and drop_q = 0 -> capture inst_o = imem_rdata_i, pc_o = pc_q, pcn_o = pc_q + 4, inst_valid_o = 1; pc_q <= pc_q + 4; go to OUT.
  - imem_rvalid_i = 1 and drop_q = 1 -> discard the data, clear drop_q, go to REQ.
- OUT:
  - Outputs are held stable while stall_i = 1.
  - stall_i = 0 -> instruction is consumed this cycle; inst_valid_o <= 0; go to REQ.
- Latency and throughput:
  - Granted in the first REQ cycle plus rvalid one cycle after gnt gives inst_valid_o 2 cycles after REQ entry.
  - Peak throughput is 1 instruction per 3 cycles.
- Redirect has priority over every other event in every state:
  - pc_q <= redirect_pc_i; inst_valid_o <= 0 next cycle (the OUT instruction is squashed even if stall_i = 1).
  - REQ without gnt -> stay in REQ with the new address.
  - REQ with gnt in the same cycle -> drop_q <= 1, go to WAIT.
  - WAIT without rvalid -> drop_q <= 1, stay in WAIT.
  - WAIT with rvalid in the same cycle -> data discarded, drop_q stays 0, go to REQ.
  - OUT -> go to REQ.
- Only one request is outstanding at a time. imem_rvalid_i outside WAIT is ignored.
- Arithmetic: pc + 4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC + 4 = 0). There is no carry out.
- rst asserted mid-transaction returns the block to the reset state next cycle. The memory must not return rvalid for a request abandoned by reset.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_o (1 bit, reset 0).
  - When redirect_i = 1 and redirect_pc_i[1:0] != 0, misalign_o pulses high for exactly one cycle (registered).
  - pc_q loads redirect_pc_i with bits [1:0] cleared.
- Not defined:
  - Port misalign_o is absent.
  - redirect_pc_i is loaded unmodified.

Test Plan:
- Reset then a memory that grants immediately and returns rvalid 1 cycle after gnt, with stall_i = 0 -> imem_addr_o sequence 0x0, 0x4, 0x8; pc_o/pcn_o = 0x0/0x4, 0x4/0x8, with one instruction every 3 cycles.
- stall_i = 1 for 5 cycles in OUT with pc_o = 0x4 -> inst_o, pc_o and pcn_o are unchanged for those 5 cycles, with no imem_req_o; after release, the next request is to 0x8.
- Redirect to 0x100 while in WAIT; the stale rvalid returns 0xDEADBEEF 2 cycles later -> 0xDEADBEEF is never presented; the next request is to 0x100 and inst_valid_o rises with pc_o = 0x100.
- Redirect to 0x200 in the same cycle as rvalid, and separately in the same cycle as gnt -> both stale responses are discarded; the first valid instruction has pc_o = 0x200.
- RESET_PC = 32'hFFFF_FFFC -> first pc_o = 0xFFFF_FFFC, pcn_o = 0x0; the next request address is 0x0.
- With IF_MISALIGN_CHK_EN defined, redirect to 0x102 -> misalign_o is high for 1 cycle and the next request is to 0x100. Without the macro, the next request is to 0x102.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: IF stage owning the PC; single-outstanding req/gnt/rvalid imem fetch.
// IF_MISALIGN_CHK_EN adds misalign_o and word-aligns redirect targets.
module if_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pcn_o,
  output logic                  inst_valid_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic                  misalign_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [DATA_WIDTH-1:0] r_pco;
  logic [DATA_WIDTH-1:0] r_pcn;
  logic                  r_drop;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] w_pc_inc;
  logic [DATA_WIDTH-1:0] w_tgt;
  logic                  w_capture;

  assign w_pc_inc = r_pc + DATA_WIDTH'(4);

`ifdef IF_MISALIGN_CHK_EN
  logic r_mis;

  assign w_tgt      = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign misalign_o = r_mis;

  always_ff @(posedge clk) begin
    if (rst) r_mis <= 1'b0;
    else     r_mis <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
  end
`else
  assign w_tgt = redirect_pc_i;
`endif

  // A response is only kept if nothing squashed it before or during rvalid
  assign w_capture = (r_state == S_WAIT) && imem_rvalid_i &&
                     !r_drop && !redirect_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ:  if (imem_gnt_i) w_next = S_WAIT;
      S_WAIT: if (imem_rvalid_i) w_next = w_capture ? S_OUT : S_REQ;
      S_OUT:  if (redirect_i || !stall_i) w_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pco   <= '0;
      r_pcn   <= '0;
    end else if (redirect_i) begin
      r_pc    <= w_tgt;
      r_valid <= 1'b0;
      if (r_state == S_REQ && imem_gnt_i)
        r_drop <= 1'b1;
      else if (r_state == S_WAIT)
        r_drop <= !imem_rvalid_i;
    end else begin
      if (w_capture) begin
        r_inst  <= imem_rdata_i;
        r_pco   <= r_pc;
        r_pcn   <= w_pc_inc;
        r_valid <= 1'b1;
        r_pc    <= w_pc_inc;
      end
      if (r_state == S_WAIT && imem_rvalid_i && r_drop)
        r_drop <= 1'b0;
      if (r_state == S_OUT && !stall_i)
        r_valid <= 1'b0;
    end
  end

  assign imem_req_o   = (r_state == S_REQ);
  assign imem_addr_o  = (r_state == S_IDLE) ? '0 : r_pc;
  assign inst_o       = r_inst;
  assign pc_o         = r_pco;
  assign pcn_o        = r_pcn;
  assign inst_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch with a configurable imem responder.
// Second instance covers the RESET_PC wrap case.
`timescale 1ns/1ps
module tb_if_fetch;

  localparam logic [31:0] RPC1  = 32'hFFFF_FFFC;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;
  localparam logic [31:0] BNOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] inst_o, pc_o, pcn_o;
  logic        inst_valid_o;

  logic        b_stall = 1'b0;
  logic        b_redir = 1'b0;
  logic [31:0] b_rpc = '0;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_gnt = 1'b0;
  logic        b_rv = 1'b0;
  logic [31:0] b_rdata = '0;
  logic [31:0] b_inst, b_pc, b_pcn;
  logic        b_valid;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_o;
  logic        b_mis;
`endif

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst),
    .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .pc_o(pc_o), .pcn_o(pcn_o),
    .inst_valid_o(inst_valid_o)
`ifdef IF_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  if_fetch #(.DATA_WIDTH(32), .RESET_PC(RPC1)) dut_b (
    .clk(clk), .rst(rst),
    .stall_i(b_stall), .redirect_i(b_redir),
    .redirect_pc_i(b_rpc),
    .imem_req_o(b_req), .imem_addr_o(b_addr),
    .imem_gnt_i(b_gnt), .imem_rvalid_i(b_rv),
    .imem_rdata_i(b_rdata),
    .inst_o(b_inst), .pc_o(b_pc), .pcn_o(b_pcn),
    .inst_valid_o(b_valid)
`ifdef IF_MISALIGN_CHK_EN
    , .misalign_o(b_mis)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IF_MISALIGN_CHK_EN
    return {a[31:2], 2'b00};
`else
    return a;
`endif
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sbq[$];
  int   gnt_wait_cfg = 0;
  int   rv_delay = 1;
  bit   track_rate = 1'b0;

  // imem responder + fetch-PC reference model for dut
  initial begin
    logic        pend;
    logic        killed;
    int          cnt;
    int          gw;
    logic [31:0] paddr;
    logic [31:0] exp_pc;
    pend = 0; killed = 0; cnt = 0; gw = 0;
    paddr = '0; exp_pc = '0;
    forever begin
      @(negedge clk); #1;
      imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0;
      if (rst) begin
        pend = 0; exp_pc = '0; gw = gnt_wait_cfg;
        continue;
      end
      if (pend) begin
        if (redirect_i) killed = 1;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          pend = 0;
          imem_rdata_i = killed ? STALE : inst_of(paddr);
          if (!killed) begin
            sbq.push_back('{paddr, inst_of(paddr)});
            exp_pc = paddr + 32'd4;
          end
        end else cnt--;
      end else if (imem_req_o) begin
        if (gw == 0) begin
          imem_gnt_i = 1'b1;
          pend = 1;
          killed = redirect_i;
          cnt = rv_delay - 1;
          paddr = exp_pc;
          chk("req_addr", imem_addr_o, exp_pc);
          gw = gnt_wait_cfg;
        end else gw--;
      end else gw = gnt_wait_cfg;
      if (redirect_i) exp_pc = tgt(redirect_pc_i);
    end
  end

  // output monitor: compare each newly presented instruction
  initial begin
    logic pv;
    int   cyc;
    int   last;
    exp_t e;
    pv = 0; cyc = 0; last = -1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        pv = 0;
        continue;
      end
      if (inst_valid_o && !pv) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("inst", inst_o, e.inst);
          chk("pc", pc_o, e.pc);
          chk("pcn", pcn_o, e.pc + 32'd4);
        end
        if (track_rate && last >= 0) chk("rate", cyc - last, 3);
        last = cyc;
      end
      pv = inst_valid_o;
    end
  end

  // responder and checks for the RESET_PC = FFFF_FFFC instance
  initial begin
    logic pend;
    logic seen;
    int   ng;
    pend = 0; seen = 0; ng = 0;
    forever begin
      @(negedge clk); #1;
      b_gnt = 1'b0;
      b_rv = 1'b0;
      if (rst) begin
        pend = 0;
        continue;
      end
      if (b_valid && !seen) begin
        chk("b_pc", b_pc, RPC1);
        chk("b_pcn", b_pcn, 32'h0);
        chk("b_inst", b_inst, BNOP);
        seen = 1;
      end
      if (pend) begin
        b_rv = 1'b1;
        b_rdata = BNOP;
        pend = 0;
      end else if (b_req) begin
        b_gnt = 1'b1;
        pend = 1;
        if (ng == 0) chk("b_addr0", b_addr, RPC1);
        else if (ng == 1) chk("b_addr1", b_addr, 32'h0);
        ng++;
      end
    end
  end

  task automatic wait_valid_pc(input logic [31:0] pc, input string tag);
    int n;
    n = 0;
    while (!(inst_valid_o && pc_o == pc) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, pc_o, pc);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!imem_req_o && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, imem_req_o, 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_pcn", pcn_o, 0);
    chk("b_rst_addr", b_addr, 0);
    rst = 1'b0;
    #2;
    chk("idle_req", imem_req_o, 0);

    track_rate = 1'b1;
    wait_valid_pc(32'h0, "w_pc0");
    wait_valid_pc(32'h4, "w_pc4");
    stall_i = 1'b1;
    track_rate = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_pc", pc_o, 32'h4);
      chk("stall_pcn", pcn_o, 32'h8);
      chk("stall_inst", inst_o, inst_of(32'h4));
      chk("stall_valid", inst_valid_o, 1);
      chk("stall_req", imem_req_o, 0);
    end
    @(negedge clk);
    stall_i = 1'b0;
    wait_valid_pc(32'h8, "w_pc8");

    rv_delay = 3;
    wait_req("t3_req");
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid_pc(32'h100, "w_pc100");
    rv_delay = 1;

    wait_req("t4a_req");
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid_pc(32'h200, "w_pc200a");

    wait_req("t4b_req");
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid_pc(32'h200, "w_pc200b");

    gnt_wait_cfg = 3;
    wait_req("t5_req");
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid_pc(32'h300, "w_pc300");
    gnt_wait_cfg = 0;

    wait_req("t6_req");
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    @(posedge clk); #1;
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_hi", misalign_o, 1);
`endif
    @(negedge clk);
    redirect_i = 1'b0;
    @(posedge clk); #1;
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_lo", misalign_o, 0);
`endif
    wait_valid_pc(tgt(32'h102), "w_pc102");

    wait_req("t7_req");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req", imem_req_o, 0);
    chk("mid_rst_valid", inst_valid_o, 0);
    chk("mid_rst_addr", imem_addr_o, 0);
    chk("mid_rst_pc", pc_o, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid_pc(32'h0, "w_after_rst");

    repeat (4) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
